// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel,
// branch redirect input and the decoder-facing instruction handshake.
interface instruction_fetch_unit_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_error;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] instruction;
   logic [31:0] instruction_pc;
   logic        instruction_valid;
   logic        instruction_ready;
   logic        fetch_fault;

   // The fetch unit itself
   modport master (
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready,
      input  mem_resp_valid, mem_resp_data, mem_resp_error,
      input  redirect_valid, redirect_pc,
      output instruction, instruction_pc, instruction_valid,
      input  instruction_ready,
      output fetch_fault
   );

   // Memory, branch unit and decoder side
   modport slave (
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready,
      output mem_resp_valid, mem_resp_data, mem_resp_error,
      output redirect_valid, redirect_pc,
      input  instruction, instruction_pc, instruction_valid,
      output instruction_ready,
      input  fetch_fault
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues credit-limited word
// reads, buffers in-order responses in a small FIFO and hands one
// instruction per cycle to decode. Redirects flush the FIFO and mark the
// requests still in flight as stale so their responses are dropped.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          BUFFER_DEPTH = 2
) (
   input logic                        clock,
   input logic                        reset,
   instruction_fetch_unit_if.master   bus
);
   localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

   typedef enum logic {RUN, FAULT} state_t;

   state_t             state_q,       state_d;
   logic [31:0]        fetch_pc_q,    fetch_pc_d;
   logic               req_valid_q,   req_valid_d;
   logic               fault_q,       fault_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;
   logic [CNT_W-1:0]   discard_q,     discard_d;
   logic [31:0]        resp_pc_q,     resp_pc_d;
   logic [PTR_W-1:0]   head_q,        head_d;
   logic [PTR_W-1:0]   tail_q,        tail_d;
   logic [CNT_W-1:0]   count_q,       count_d;
   logic [31:0]        data_q [BUFFER_DEPTH];
   logic [31:0]        data_d [BUFFER_DEPTH];
   logic [31:0]        pc_q   [BUFFER_DEPTH];
   logic [31:0]        pc_d   [BUFFER_DEPTH];
   logic               err_q  [BUFFER_DEPTH];
   logic               err_d  [BUFFER_DEPTH];

   logic               accept;
   logic               head_present;
   logic               out_valid;
   logic               head_fault;
   logic               pop;
   logic               push;
   logic               drop_resp;
   logic [CNT_W:0]     credit_used;

   assign accept       = req_valid_q & bus.mem_req_ready;
   assign head_present = (count_q != '0);
   assign out_valid    = (state_q == RUN) && head_present && !err_q[head_q];
   assign head_fault   = (state_q == RUN) && head_present &&  err_q[head_q];
   assign pop          = out_valid & bus.instruction_ready;
   assign drop_resp    = (discard_q != '0);
   assign push         = bus.mem_resp_valid && !drop_resp && (state_q == RUN);

   assign bus.mem_req_valid     = req_valid_q;
   assign bus.mem_req_addr      = fetch_pc_q;
   assign bus.instruction       = data_q[head_q];
   assign bus.instruction_pc    = pc_q[head_q];
   assign bus.instruction_valid = out_valid;
   assign bus.fetch_fault       = fault_q;

   // Next-state: request/response bookkeeping, FIFO, fault and redirect, then credit check
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      fault_d       = fault_q;
      discard_d     = discard_q;
      resp_pc_d     = resp_pc_q;
      head_d        = head_q;
      tail_d        = tail_q;
      data_d        = data_q;
      pc_d          = pc_q;
      err_d         = err_q;

      outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(bus.mem_resp_valid);
      count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

      if (accept) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (bus.mem_resp_valid && drop_resp) begin
         discard_d = discard_q - CNT_W'(1);
      end

      if (push) begin
         data_d[tail_q] = bus.mem_resp_data;
         pc_d[tail_q]   = resp_pc_q;
         err_d[tail_q]  = bus.mem_resp_error;
         tail_d         = tail_q + PTR_W'(1);
         resp_pc_d      = resp_pc_q + 32'd4;
      end

      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end

      if (head_fault) begin
         state_d = FAULT;
         fault_d = 1'b1;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end

      if (bus.redirect_valid) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         discard_d  = outstanding_d;
         fetch_pc_d = bus.redirect_pc;
         resp_pc_d  = bus.redirect_pc;
         if (bus.redirect_pc[1:0] != 2'b00) begin
            state_d = FAULT;
            fault_d = 1'b1;
         end else begin
            state_d = RUN;
            fault_d = 1'b0;
         end
      end

      credit_used = {1'b0, outstanding_d} + {1'b0, count_d};
      req_valid_d = (state_d == RUN) && !bus.redirect_valid &&
                    (credit_used < (CNT_W+1)'(BUFFER_DEPTH));
   end

   // State registers, cleared asynchronously by the active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= RUN;
         fetch_pc_q    <= RESET_PC;
         req_valid_q   <= 1'b0;
         fault_q       <= 1'b0;
         outstanding_q <= '0;
         discard_q     <= '0;
         resp_pc_q     <= RESET_PC;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         for (int i = 0; i < BUFFER_DEPTH; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
            err_q[i]  <= 1'b0;
         end
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         req_valid_q   <= req_valid_d;
         fault_q       <= fault_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         resp_pc_q     <= resp_pc_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         data_q        <= data_d;
         pc_q          <= pc_d;
         err_q         <= err_d;
      end
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with an in-order,
// fixed-latency memory model that returns the address as data.
module tb_instruction_fetch_unit;
   logic clock = 1'b0;
   logic reset = 1'b0;

   instruction_fetch_unit_if bus();

   instruction_fetch_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int          total = 0;
   int          bad   = 0;
   int          cycle = 0;
   int          mem_lat = 1;
   logic        err_en = 1'b0;
   logic [31:0] err_addr = 32'h0;
   int          acc_cnt = 0;
   int          resp_cnt = 0;
   int          max_out = 0;
   int          req_cycles = 0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] acc_log[$];
   logic [31:0] dlv_pc[$];
   logic [31:0] dlv_data[$];

   // Memory model: present the oldest response once its latency has elapsed
   task automatic drive_mem();
      if (pend_addr.size() != 0 && pend_due[0] <= cycle) begin
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = pend_addr[0];
         bus.mem_resp_error = err_en && (pend_addr[0] == err_addr);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
         resp_cnt++;
      end else begin
         bus.mem_resp_valid = 1'b0;
         bus.mem_resp_data  = 32'h0;
         bus.mem_resp_error = 1'b0;
      end
   endtask

   // One clock: record handshakes mid-cycle, then advance and drive memory
   task automatic step();
      @(negedge clock);
      if (bus.mem_req_valid && bus.mem_req_ready) begin
         pend_addr.push_back(bus.mem_req_addr);
         pend_due.push_back(cycle + mem_lat);
         acc_log.push_back(bus.mem_req_addr);
         acc_cnt++;
      end
      if (bus.instruction_valid && bus.instruction_ready) begin
         dlv_pc.push_back(bus.instruction_pc);
         dlv_data.push_back(bus.instruction);
      end
      if (bus.mem_req_valid) req_cycles++;
      if (acc_cnt - resp_cnt > max_out) max_out = acc_cnt - resp_cnt;
      @(posedge clock);
      #1;
      cycle++;
      drive_mem();
   endtask

   task automatic clear_logs();
      acc_log.delete();
      dlv_pc.delete();
      dlv_data.delete();
   endtask

   // Reset DUT and memory model together
   task automatic do_reset();
      reset = 1'b0;
      bus.redirect_valid    = 1'b0;
      bus.redirect_pc       = 32'h0;
      bus.mem_resp_valid    = 1'b0;
      bus.mem_resp_data     = 32'h0;
      bus.mem_resp_error    = 1'b0;
      bus.mem_req_ready     = 1'b1;
      bus.instruction_ready = 1'b1;
      pend_addr.delete();
      pend_due.delete();
      clear_logs();
      acc_cnt = 0; resp_cnt = 0; max_out = 0; req_cycles = 0;
      err_en = 1'b0; mem_lat = 1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      cycle = 0;
      drive_mem();
   endtask

   task automatic applyRedirect(input logic [31:0] pc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
      step();
      bus.redirect_valid = 1'b0;
   endtask

   // Reset values, including an asynchronous reset in the middle of streaming
   task automatic test_reset();
      do_reset();
      repeat (6) step();
      #2 reset = 1'b0;
      #1;
      total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_valid got=%b exp=0", bus.mem_req_valid); end
      total++; if (bus.instruction_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_instr_valid got=%b exp=0", bus.instruction_valid); end
      total++; if (bus.fetch_fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault got=%b exp=0", bus.fetch_fault); end
      total++; if (bus.mem_req_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_req_addr got=%h exp=00000000", bus.mem_req_addr); end
      total++; if (bus.instruction !== 32'h0) begin bad++; $display("[TB] FAIL reset_instr got=%h exp=00000000", bus.instruction); end
      total++; if (bus.instruction_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_instr_pc got=%h exp=00000000", bus.instruction_pc); end
   endtask

   // Free-running stream from address zero with a 1-cycle memory
   task automatic test_stream();
      logic [31:0] exp;
      do_reset();
      repeat (30) step();
      total++; if (dlv_pc.size() < 8) begin bad++; $display("[TB] FAIL stream_count got=%0d exp>=8", dlv_pc.size()); end
      for (int i = 0; i < 8 && i < dlv_pc.size(); i++) begin
         exp = 32'(4 * i);
         total++; if (dlv_pc[i] !== exp) begin bad++; $display("[TB] FAIL stream_pc[%0d] got=%h exp=%h", i, dlv_pc[i], exp); end
         total++; if (dlv_data[i] !== exp) begin bad++; $display("[TB] FAIL stream_data[%0d] got=%h exp=%h", i, dlv_data[i], exp); end
      end
      total++; if (max_out > 2) begin bad++; $display("[TB] FAIL stream_outstanding got=%0d exp<=2", max_out); end
   endtask

   // Decoder stalled: only two requests may issue, then fetch resumes at 0x8
   task automatic test_backpressure();
      do_reset();
      bus.instruction_ready = 1'b0;
      repeat (10) step();
      total++; if (acc_cnt !== 2) begin bad++; $display("[TB] FAIL bp_requests got=%0d exp=2", acc_cnt); end
      total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_req_valid got=%b exp=0", bus.mem_req_valid); end
      bus.instruction_ready = 1'b1;
      repeat (6) step();
      total++; if (dlv_pc.size() < 2) begin bad++; $display("[TB] FAIL bp_count got=%0d exp>=2", dlv_pc.size()); end
      else begin
         total++; if (dlv_pc[0] !== 32'h0) begin bad++; $display("[TB] FAIL bp_pc0 got=%h exp=00000000", dlv_pc[0]); end
         total++; if (dlv_pc[1] !== 32'h4) begin bad++; $display("[TB] FAIL bp_pc1 got=%h exp=00000004", dlv_pc[1]); end
      end
      total++; if (acc_log.size() < 3) begin bad++; $display("[TB] FAIL bp_resume_count got=%0d exp>=3", acc_log.size()); end
      else begin
         total++; if (acc_log[2] !== 32'h8) begin bad++; $display("[TB] FAIL bp_resume_addr got=%h exp=00000008", acc_log[2]); end
      end
   endtask

   // Redirect with two requests in flight: stale responses must vanish
   task automatic test_redirect();
      int n;
      do_reset();
      mem_lat = 3;
      n = 0;
      while ((acc_cnt - resp_cnt) != 2 && n < 20) begin step(); n++; end
      total++; if ((acc_cnt - resp_cnt) !== 2) begin bad++; $display("[TB] FAIL redir_inflight got=%0d exp=2", acc_cnt - resp_cnt); end
      applyRedirect(32'h100);
      clear_logs();
      repeat (25) step();
      total++; if (dlv_pc.size() < 2) begin bad++; $display("[TB] FAIL redir_count got=%0d exp>=2", dlv_pc.size()); end
      else begin
         total++; if (dlv_pc[0] !== 32'h100) begin bad++; $display("[TB] FAIL redir_pc0 got=%h exp=00000100", dlv_pc[0]); end
         total++; if (dlv_data[0] !== 32'h100) begin bad++; $display("[TB] FAIL redir_data0 got=%h exp=00000100", dlv_data[0]); end
         total++; if (dlv_pc[1] !== 32'h104) begin bad++; $display("[TB] FAIL redir_pc1 got=%h exp=00000104", dlv_pc[1]); end
      end
   endtask

   // Access fault on 0x8: two words delivered, then fault with fetch stopped
   task automatic test_fault();
      do_reset();
      err_en = 1'b1;
      err_addr = 32'h8;
      repeat (10) step();
      req_cycles = 0;
      repeat (10) step();
      total++; if (dlv_pc.size() !== 2) begin bad++; $display("[TB] FAIL fault_count got=%0d exp=2", dlv_pc.size()); end
      else begin
         total++; if (dlv_pc[0] !== 32'h0) begin bad++; $display("[TB] FAIL fault_pc0 got=%h exp=00000000", dlv_pc[0]); end
         total++; if (dlv_pc[1] !== 32'h4) begin bad++; $display("[TB] FAIL fault_pc1 got=%h exp=00000004", dlv_pc[1]); end
      end
      total++; if (bus.fetch_fault !== 1'b1) begin bad++; $display("[TB] FAIL fault_flag got=%b exp=1", bus.fetch_fault); end
      total++; if (bus.instruction_valid !== 1'b0) begin bad++; $display("[TB] FAIL fault_instr_valid got=%b exp=0", bus.instruction_valid); end
      total++; if (req_cycles !== 0) begin bad++; $display("[TB] FAIL fault_requests got=%0d exp=0", req_cycles); end
      err_en = 1'b0;
      applyRedirect(32'h40);
      clear_logs();
      repeat (15) step();
      total++; if (bus.fetch_fault !== 1'b0) begin bad++; $display("[TB] FAIL fault_clear got=%b exp=0", bus.fetch_fault); end
      total++; if (dlv_pc.size() < 2) begin bad++; $display("[TB] FAIL fault_recover_count got=%0d exp>=2", dlv_pc.size()); end
      else begin
         total++; if (dlv_pc[0] !== 32'h40) begin bad++; $display("[TB] FAIL fault_recover_pc0 got=%h exp=00000040", dlv_pc[0]); end
         total++; if (dlv_pc[1] !== 32'h44) begin bad++; $display("[TB] FAIL fault_recover_pc1 got=%h exp=00000044", dlv_pc[1]); end
      end
   endtask

   // Misaligned redirect faults; an aligned redirect recovers
   task automatic test_misaligned();
      do_reset();
      repeat (4) step();
      applyRedirect(32'h102);
      req_cycles = 0;
      repeat (6) step();
      total++; if (bus.fetch_fault !== 1'b1) begin bad++; $display("[TB] FAIL mis_fault got=%b exp=1", bus.fetch_fault); end
      total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL mis_req_valid got=%b exp=0", bus.mem_req_valid); end
      total++; if (req_cycles !== 0) begin bad++; $display("[TB] FAIL mis_requests got=%0d exp=0", req_cycles); end
      applyRedirect(32'h200);
      clear_logs();
      repeat (15) step();
      total++; if (bus.fetch_fault !== 1'b0) begin bad++; $display("[TB] FAIL mis_clear got=%b exp=0", bus.fetch_fault); end
      total++; if (dlv_pc.size() < 2) begin bad++; $display("[TB] FAIL mis_count got=%0d exp>=2", dlv_pc.size()); end
      else begin
         total++; if (dlv_pc[0] !== 32'h200) begin bad++; $display("[TB] FAIL mis_pc0 got=%h exp=00000200", dlv_pc[0]); end
         total++; if (dlv_pc[1] !== 32'h204) begin bad++; $display("[TB] FAIL mis_pc1 got=%h exp=00000204", dlv_pc[1]); end
      end
   endtask

   // PC wrap at the top of memory, then redirect colliding with handshake and response
   task automatic test_back_to_back();
      logic [31:0] exp_wrap [4];
      logic [31:0] exp;
      int n;
      exp_wrap[0] = 32'hFFFF_FFF8; exp_wrap[1] = 32'hFFFF_FFFC;
      exp_wrap[2] = 32'h0000_0000; exp_wrap[3] = 32'h0000_0004;
      do_reset();
      repeat (2) step();
      applyRedirect(32'hFFFF_FFF8);
      clear_logs();
      repeat (12) step();
      total++; if (acc_log.size() < 3) begin bad++; $display("[TB] FAIL wrap_req_count got=%0d exp>=3", acc_log.size()); end
      else begin
         total++; if (acc_log[2] !== 32'h0) begin bad++; $display("[TB] FAIL wrap_req_addr got=%h exp=00000000", acc_log[2]); end
      end
      total++; if (dlv_pc.size() < 4) begin bad++; $display("[TB] FAIL wrap_count got=%0d exp>=4", dlv_pc.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            total++; if (dlv_pc[i] !== exp_wrap[i]) begin bad++; $display("[TB] FAIL wrap_pc[%0d] got=%h exp=%h", i, dlv_pc[i], exp_wrap[i]); end
            total++; if (dlv_data[i] !== exp_wrap[i]) begin bad++; $display("[TB] FAIL wrap_data[%0d] got=%h exp=%h", i, dlv_data[i], exp_wrap[i]); end
         end
      end
      n = 0;
      while (!(bus.instruction_valid && bus.instruction_ready && bus.mem_resp_valid) && n < 40) begin step(); n++; end
      total++; if (n >= 40) begin bad++; $display("[TB] FAIL corner_found got=%0d exp<40", n); end
      applyRedirect(32'h300);
      clear_logs();
      max_out = 0;
      repeat (20) step();
      total++; if (dlv_pc.size() < 4) begin bad++; $display("[TB] FAIL corner_count got=%0d exp>=4", dlv_pc.size()); end
      for (int i = 0; i < dlv_pc.size(); i++) begin
         exp = 32'h300 + 32'(4 * i);
         total++; if (dlv_pc[i] !== exp) begin bad++; $display("[TB] FAIL corner_pc[%0d] got=%h exp=%h", i, dlv_pc[i], exp); end
         total++; if (dlv_data[i] !== exp) begin bad++; $display("[TB] FAIL corner_data[%0d] got=%h exp=%h", i, dlv_data[i], exp); end
      end
      total++; if (max_out > 2) begin bad++; $display("[TB] FAIL corner_outstanding got=%0d exp<=2", max_out); end
      total++; if (bus.fetch_fault !== 1'b0) begin bad++; $display("[TB] FAIL corner_fault got=%b exp=0", bus.fetch_fault); end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_fault();
      test_misaligned();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
